// File: rtl/bscan_arbiter_if.sv
// Handshake bundle between two request clients, the shared Bscan channel and
// the two indication return channels. The arbiter uses the slave modport.
interface bscan_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req0_enq__ENA;
    logic [WIDTH-3:0] req0_enq_v;
    logic             req0_enq__RDY;
    logic             req1_enq__ENA;
    logic [WIDTH-3:0] req1_enq_v;
    logic             req1_enq__RDY;

    logic             bscan_enq__ENA;
    logic [WIDTH-1:0] bscan_enq_v;
    logic             bscan_enq__RDY;

    logic             from_enq__ENA;
    logic [WIDTH-1:0] from_enq_v;
    logic             from_enq__RDY;

    logic             ind0_enq__ENA;
    logic [WIDTH-3:0] ind0_enq_v;
    logic             ind0_enq__RDY;
    logic             ind1_enq__ENA;
    logic [WIDTH-3:0] ind1_enq_v;
    logic             ind1_enq__RDY;

    logic [7:0]       drop_count;

    modport slave (
        input  req0_enq__ENA, req0_enq_v, req1_enq__ENA, req1_enq_v,
        output req0_enq__RDY, req1_enq__RDY,
        output bscan_enq__ENA, bscan_enq_v,
        input  bscan_enq__RDY,
        input  from_enq__ENA, from_enq_v,
        output from_enq__RDY,
        output ind0_enq__ENA, ind0_enq_v, ind1_enq__ENA, ind1_enq_v,
        input  ind0_enq__RDY, ind1_enq__RDY,
        output drop_count
    );

    modport master (
        output req0_enq__ENA, req0_enq_v, req1_enq__ENA, req1_enq_v,
        input  req0_enq__RDY, req1_enq__RDY,
        input  bscan_enq__ENA, bscan_enq_v,
        output bscan_enq__RDY,
        output from_enq__ENA, from_enq_v,
        input  from_enq__RDY,
        input  ind0_enq__ENA, ind0_enq_v, ind1_enq__ENA, ind1_enq_v,
        output ind0_enq__RDY, ind1_enq__RDY,
        input  drop_count
    );
endinterface

// File: rtl/bscan_arbiter.sv
// Two-client round-robin arbiter onto one tagged Bscan word stream, with a
// combinational tag-decoded return path and a saturating unrouted-word counter.
module bscan_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input logic            CLK,
    input logic            nRST,
    bscan_arbiter_if.slave bus
);
    localparam int unsigned PW = WIDTH - 2;

    logic             valid0_q, valid0_d, valid1_q, valid1_d;
    logic [PW-1:0]    data0_q, data0_d, data1_q, data1_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             last_q, last_d;
    logic [7:0]       drop_count_q, drop_count_d;

    logic take0, take1, can_grant, grant0, grant1, out_fire;
    logic [1:0]    from_tag;
    logic [PW-1:0] from_payload;

    assign bus.req0_enq__RDY  = !valid0_q;
    assign bus.req1_enq__RDY  = !valid1_q;
    assign bus.bscan_enq__ENA = out_valid_q;
    assign bus.bscan_enq_v    = out_data_q;
    assign bus.drop_count     = drop_count_q;

    // Send path: buffer capture, grant and output stage
    always_comb begin
        take0     = bus.req0_enq__ENA && !valid0_q;
        take1     = bus.req1_enq__ENA && !valid1_q;
        out_fire  = out_valid_q && bus.bscan_enq__RDY;
        can_grant = !out_valid_q || bus.bscan_enq__RDY;
        // On a tie the client that was not granted last wins
        grant0    = can_grant && valid0_q && (!valid1_q || last_q);
        grant1    = can_grant && valid1_q && (!valid0_q || !last_q);

        valid0_d = valid0_q;
        data0_d  = data0_q;
        if (take0) begin
            valid0_d = 1'b1;
            data0_d  = bus.req0_enq_v;
        end else if (grant0) begin
            valid0_d = 1'b0;
        end

        valid1_d = valid1_q;
        data1_d  = data1_q;
        if (take1) begin
            valid1_d = 1'b1;
            data1_d  = bus.req1_enq_v;
        end else if (grant1) begin
            valid1_d = 1'b0;
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        last_d      = last_q;
        if (grant0) begin
            out_valid_d = 1'b1;
            out_data_d  = {2'b00, data0_q};
            last_d      = 1'b0;
        end else if (grant1) begin
            out_valid_d = 1'b1;
            out_data_d  = {2'b01, data1_q};
            last_d      = 1'b1;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    // Return path: purely combinational routing by tag
    always_comb begin
        from_tag          = bus.from_enq_v[WIDTH-1:WIDTH-2];
        from_payload      = bus.from_enq_v[PW-1:0];
        bus.ind0_enq__ENA = bus.from_enq__ENA && (from_tag == 2'b00);
        bus.ind1_enq__ENA = bus.from_enq__ENA && (from_tag == 2'b01);
        bus.ind0_enq_v    = bus.ind0_enq__ENA ? from_payload : '0;
        bus.ind1_enq_v    = bus.ind1_enq__ENA ? from_payload : '0;
        case (from_tag)
            2'b00:   bus.from_enq__RDY = bus.ind0_enq__RDY;
            2'b01:   bus.from_enq__RDY = bus.ind1_enq__RDY;
            default: bus.from_enq__RDY = 1'b1;
        endcase

        drop_count_d = drop_count_q;
        if (bus.from_enq__ENA && from_tag[1] && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid0_q     <= 1'b0;
            valid1_q     <= 1'b0;
            data0_q      <= '0;
            data1_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            last_q       <= 1'b1;
            drop_count_q <= 8'h00;
        end else begin
            valid0_q     <= valid0_d;
            valid1_q     <= valid1_d;
            data0_q      <= data0_d;
            data1_q      <= data1_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            last_q       <= last_d;
            drop_count_q <= drop_count_d;
        end
    end
endmodule

// File: tb/tb_bscan_arbiter.sv
// Self-checking bench for bscan_arbiter: directed sequences, a return-path vector
// table and a randomized run against a queue-based scoreboard.
module tb_bscan_arbiter;
    logic CLK = 1'b0;
    logic nRST = 1'b0;

    bscan_arbiter_if #(.WIDTH(32)) bus ();

    bscan_arbiter #(.WIDTH(32)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        ena;
        logic [31:0] v;
        logic        r0;
        logic        r1;
        logic        exp_rdy;
        logic        exp_e0;
        logic [29:0] exp_v0;
        logic        exp_e1;
        logic [29:0] exp_v1;
    } ret_vec_t;

    ret_vec_t    tbl [8];
    logic [29:0] q0 [$];
    logic [29:0] q1 [$];
    logic [29:0] exp_pay;
    logic [1:0]  t;
    logic [31:0] prev_v;
    logic        hold;
    int          drop_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.req0_enq__ENA  = 1'b0;
        bus.req0_enq_v     = '0;
        bus.req1_enq__ENA  = 1'b0;
        bus.req1_enq_v     = '0;
        bus.bscan_enq__RDY = 1'b1;
        bus.from_enq__ENA  = 1'b0;
        bus.from_enq_v     = '0;
        bus.ind0_enq__RDY  = 1'b1;
        bus.ind1_enq__RDY  = 1'b1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        idle();
        step();
        step();
        nRST = 1'b1;
    endtask

    // Both clients offer in the same cycle; client 0 must win when last == 1
    task automatic run_tie(input string tag);
        bus.req0_enq__ENA = 1'b1;
        bus.req0_enq_v    = 30'hA;
        bus.req1_enq__ENA = 1'b1;
        bus.req1_enq_v    = 30'hB;
        @(negedge CLK);
        chk({tag, "_c1_ena"}, 32'(bus.bscan_enq__ENA), 32'd0);
        step();
        bus.req0_enq__ENA = 1'b0;
        bus.req1_enq__ENA = 1'b0;
        @(negedge CLK);
        chk({tag, "_c2_ena"}, 32'(bus.bscan_enq__ENA), 32'd0);
        step();
        @(negedge CLK);
        chk({tag, "_c3_ena"}, 32'(bus.bscan_enq__ENA), 32'd1);
        chk({tag, "_c3_v"}, bus.bscan_enq_v, 32'h0000000A);
        step();
        @(negedge CLK);
        chk({tag, "_c4_ena"}, 32'(bus.bscan_enq__ENA), 32'd1);
        chk({tag, "_c4_v"}, bus.bscan_enq_v, 32'h4000000B);
        step();
        @(negedge CLK);
        chk({tag, "_c5_ena"}, 32'(bus.bscan_enq__ENA), 32'd0);
        step();
    endtask

    initial begin
        tbl[0] = '{1'b1, 32'h00000123, 1'b1, 1'b1, 1'b1, 1'b1, 30'h123, 1'b0, 30'h0};
        tbl[1] = '{1'b1, 32'h00000123, 1'b0, 1'b1, 1'b0, 1'b1, 30'h123, 1'b0, 30'h0};
        tbl[2] = '{1'b1, 32'h40000055, 1'b1, 1'b0, 1'b0, 1'b0, 30'h0, 1'b1, 30'h55};
        tbl[3] = '{1'b1, 32'h40000055, 1'b0, 1'b1, 1'b1, 1'b0, 30'h0, 1'b1, 30'h55};
        tbl[4] = '{1'b1, 32'h80000077, 1'b0, 1'b0, 1'b1, 1'b0, 30'h0, 1'b0, 30'h0};
        tbl[5] = '{1'b1, 32'hC0000001, 1'b0, 1'b0, 1'b1, 1'b0, 30'h0, 1'b0, 30'h0};
        tbl[6] = '{1'b0, 32'h00000123, 1'b1, 1'b1, 1'b1, 1'b0, 30'h0, 1'b0, 30'h0};
        tbl[7] = '{1'b0, 32'h40000055, 1'b1, 1'b0, 1'b0, 1'b0, 30'h0, 1'b0, 30'h0};

        // Reset state
        do_reset();
        @(negedge CLK);
        chk("rst_bscan_ena", 32'(bus.bscan_enq__ENA), 32'd0);
        chk("rst_req0_rdy", 32'(bus.req0_enq__RDY), 32'd1);
        chk("rst_req1_rdy", 32'(bus.req1_enq__RDY), 32'd1);
        chk("rst_drop", 32'(bus.drop_count), 32'd0);
        step();

        // Single client latency and one-cycle pulse
        bus.req0_enq__ENA = 1'b1;
        bus.req0_enq_v    = 30'h1234;
        @(negedge CLK);
        chk("single_c1_ena", 32'(bus.bscan_enq__ENA), 32'd0);
        step();
        bus.req0_enq__ENA = 1'b0;
        @(negedge CLK);
        chk("single_c2_ena", 32'(bus.bscan_enq__ENA), 32'd0);
        step();
        @(negedge CLK);
        chk("single_c3_ena", 32'(bus.bscan_enq__ENA), 32'd1);
        chk("single_c3_v", bus.bscan_enq_v, 32'h00001234);
        step();
        @(negedge CLK);
        chk("single_c4_ena", 32'(bus.bscan_enq__ENA), 32'd0);
        step();

        do_reset();
        run_tie("tie");

        // Backpressure with both buffers filling
        do_reset();
        bus.bscan_enq__RDY = 1'b0;
        bus.req0_enq__ENA  = 1'b1;
        bus.req0_enq_v     = 30'h11;
        bus.req1_enq__ENA  = 1'b1;
        bus.req1_enq_v     = 30'h22;
        step();
        bus.req0_enq__ENA = 1'b0;
        bus.req1_enq__ENA = 1'b0;
        step();
        bus.req0_enq__ENA = 1'b1;
        bus.req0_enq_v    = 30'h33;
        @(negedge CLK);
        chk("bp_req0_rdy_c3", 32'(bus.req0_enq__RDY), 32'd1);
        step();
        bus.req0_enq__ENA = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("bp_hold_ena", 32'(bus.bscan_enq__ENA), 32'd1);
            chk("bp_hold_v", bus.bscan_enq_v, 32'h00000011);
            chk("bp_req0_rdy", 32'(bus.req0_enq__RDY), 32'd0);
            chk("bp_req1_rdy", 32'(bus.req1_enq__RDY), 32'd0);
            step();
        end
        bus.bscan_enq__RDY = 1'b1;
        @(negedge CLK);
        chk("bp_w0", bus.bscan_enq_v, 32'h00000011);
        step();
        @(negedge CLK);
        chk("bp_w1_ena", 32'(bus.bscan_enq__ENA), 32'd1);
        chk("bp_w1", bus.bscan_enq_v, 32'h40000022);
        step();
        @(negedge CLK);
        chk("bp_w2_ena", 32'(bus.bscan_enq__ENA), 32'd1);
        chk("bp_w2", bus.bscan_enq_v, 32'h00000033);
        step();
        @(negedge CLK);
        chk("bp_end_ena", 32'(bus.bscan_enq__ENA), 32'd0);
        step();

        // Return-path vector table; ENA is dropped before each edge
        for (int i = 0; i < 8; i++) begin
            bus.from_enq__ENA = tbl[i].ena;
            bus.from_enq_v    = tbl[i].v;
            bus.ind0_enq__RDY = tbl[i].r0;
            bus.ind1_enq__RDY = tbl[i].r1;
            #1;
            chk($sformatf("ret%0d_rdy", i), 32'(bus.from_enq__RDY), 32'(tbl[i].exp_rdy));
            chk($sformatf("ret%0d_e0", i), 32'(bus.ind0_enq__ENA), 32'(tbl[i].exp_e0));
            chk($sformatf("ret%0d_v0", i), 32'(bus.ind0_enq_v), 32'(tbl[i].exp_v0));
            chk($sformatf("ret%0d_e1", i), 32'(bus.ind1_enq__ENA), 32'(tbl[i].exp_e1));
            chk($sformatf("ret%0d_v1", i), 32'(bus.ind1_enq_v), 32'(tbl[i].exp_v1));
            bus.from_enq__ENA = 1'b0;
            step();
        end
        idle();
        @(negedge CLK);
        chk("ret_drop_zero", 32'(bus.drop_count), 32'd0);
        step();

        // Saturating drop counter
        for (int i = 0; i < 300; i++) begin
            bus.from_enq__ENA = 1'b1;
            bus.from_enq_v    = {2'b11, 30'($urandom)};
            @(negedge CLK);
            chk("drop_rdy", 32'(bus.from_enq__RDY), 32'd1);
            if (i == 100) chk("drop_mid", 32'(bus.drop_count), 32'd100);
            step();
        end
        bus.from_enq__ENA = 1'b0;
        @(negedge CLK);
        chk("drop_sat", 32'(bus.drop_count), 32'hFF);
        step();

        // Reset mid-flow: last is left at 0, reset must restore client 0 priority
        do_reset();
        bus.from_enq__ENA = 1'b1;
        bus.from_enq_v    = 32'hC0000000;
        bus.bscan_enq__RDY = 1'b0;
        bus.req0_enq__ENA = 1'b1;
        bus.req0_enq_v    = 30'h77;
        step();
        bus.from_enq__ENA = 1'b0;
        bus.req0_enq__ENA = 1'b0;
        step();
        bus.req1_enq__ENA = 1'b1;
        bus.req1_enq_v    = 30'h88;
        @(negedge CLK);
        chk("mid_pre_ena", 32'(bus.bscan_enq__ENA), 32'd1);
        chk("mid_pre_drop", 32'(bus.drop_count), 32'd1);
        step();
        nRST = 1'b0;
        idle();
        step();
        nRST = 1'b1;
        @(negedge CLK);
        chk("mid_ena", 32'(bus.bscan_enq__ENA), 32'd0);
        chk("mid_drop", 32'(bus.drop_count), 32'd0);
        chk("mid_req0_rdy", 32'(bus.req0_enq__RDY), 32'd1);
        chk("mid_req1_rdy", 32'(bus.req1_enq__RDY), 32'd1);
        step();
        run_tie("mid_tie");

        // Randomized traffic against a per-client FIFO scoreboard
        do_reset();
        drop_m = 0;
        hold   = 1'b0;
        prev_v = '0;
        for (int c = 0; c < 3000; c++) begin
            bus.req0_enq__ENA  = 1'($urandom_range(0, 1));
            bus.req0_enq_v     = 30'($urandom);
            bus.req1_enq__ENA  = 1'($urandom_range(0, 1));
            bus.req1_enq_v     = 30'($urandom);
            bus.bscan_enq__RDY = ($urandom_range(0, 9) < 7);
            bus.from_enq__ENA  = 1'($urandom_range(0, 1));
            bus.from_enq_v     = $urandom;
            bus.ind0_enq__RDY  = 1'($urandom_range(0, 1));
            bus.ind1_enq__RDY  = 1'($urandom_range(0, 1));
            @(negedge CLK);
            t = bus.from_enq_v[31:30];
            chk("rnd_from_rdy", 32'(bus.from_enq__RDY),
                32'((t == 2'd0) ? bus.ind0_enq__RDY : (t == 2'd1) ? bus.ind1_enq__RDY : 1'b1));
            chk("rnd_ind0_ena", 32'(bus.ind0_enq__ENA), 32'(bus.from_enq__ENA && t == 2'd0));
            chk("rnd_ind1_ena", 32'(bus.ind1_enq__ENA), 32'(bus.from_enq__ENA && t == 2'd1));
            chk("rnd_ind0_v", 32'(bus.ind0_enq_v),
                (bus.from_enq__ENA && t == 2'd0) ? {2'b00, bus.from_enq_v[29:0]} : 32'd0);
            chk("rnd_ind1_v", 32'(bus.ind1_enq_v),
                (bus.from_enq__ENA && t == 2'd1) ? {2'b00, bus.from_enq_v[29:0]} : 32'd0);
            chk("rnd_drop", 32'(bus.drop_count), 32'(drop_m));
            if (hold) begin
                chk("rnd_hold_ena", 32'(bus.bscan_enq__ENA), 32'd1);
                chk("rnd_hold_v", bus.bscan_enq_v, prev_v);
            end
            if (bus.req0_enq__ENA && bus.req0_enq__RDY) q0.push_back(bus.req0_enq_v);
            if (bus.req1_enq__ENA && bus.req1_enq__RDY) q1.push_back(bus.req1_enq_v);
            if (bus.bscan_enq__ENA && bus.bscan_enq__RDY) begin
                t = bus.bscan_enq_v[31:30];
                if (t == 2'd0 && q0.size() > 0) begin
                    exp_pay = q0.pop_front();
                    chk("rnd_word0", bus.bscan_enq_v, {2'b00, exp_pay});
                end else if (t == 2'd1 && q1.size() > 0) begin
                    exp_pay = q1.pop_front();
                    chk("rnd_word1", bus.bscan_enq_v, {2'b01, exp_pay});
                end else begin
                    chk("rnd_spurious", bus.bscan_enq_v, 32'hFFFFFFFF);
                end
            end
            hold   = bus.bscan_enq__ENA && !bus.bscan_enq__RDY;
            prev_v = bus.bscan_enq_v;
            if (bus.from_enq__ENA && bus.from_enq_v[31] && drop_m < 255) drop_m++;
            step();
        end

        // Drain: every accepted word must come out within a bounded window
        idle();
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (bus.bscan_enq__ENA) begin
                t = bus.bscan_enq_v[31:30];
                if (t == 2'd0 && q0.size() > 0) begin
                    exp_pay = q0.pop_front();
                    chk("drain_word0", bus.bscan_enq_v, {2'b00, exp_pay});
                end else if (t == 2'd1 && q1.size() > 0) begin
                    exp_pay = q1.pop_front();
                    chk("drain_word1", bus.bscan_enq_v, {2'b01, exp_pay});
                end else begin
                    chk("drain_spurious", bus.bscan_enq_v, 32'hFFFFFFFF);
                end
            end
            step();
        end
        chk("drain_q0_empty", 32'(q0.size()), 32'd0);
        chk("drain_q1_empty", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
